// File: rtl/cardinal_ring_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cardinal_ring_out_arbiter
// Brief    : Per-direction output arbiter with one-entry VC0/VC1 buffers and
//            polarity-phased draining onto the outbound ring link.
// Revision : 1.0 - initial release
// ============================================================================
module cardinal_ring_out_arbiter #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              polarity,
    input  logic              ring_req,
    input  logic [DATA_W-1:0] ring_data,
    output logic              ring_gnt,
    input  logic              local_req,
    input  logic [DATA_W-1:0] local_data,
    output logic              local_gnt,
    output logic              out_so,
    input  logic              out_ro,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  sent_cnt
);

    localparam logic c_PRIO_RING = 1'b0;

    logic              r_polarity;
    logic [1:0]        r_full;
    logic [1:0]        r_prio;
    logic [DATA_W-1:0] r_buf [2];
    logic [CNT_W-1:0]  r_sent_cnt;

    logic              w_ring_vc;
    logic              w_local_vc;
    logic              w_ring_elig;
    logic              w_local_elig;
    logic              w_fill_vc;
    logic              w_contend;
    logic              w_ring_gnt;
    logic              w_local_gnt;
    logic              w_fill;
    logic              w_drain;
    logic [DATA_W-1:0] w_fill_data;

    // Only the VC opposite the current phase may fill, so both requesters
    // can only ever contend for the same buffer.
    always_comb begin
        w_ring_vc    = ring_data[0];
        w_local_vc   = local_data[0];
        w_fill_vc    = ~r_polarity;
        w_ring_elig  = ring_req  & ~r_full[w_ring_vc]  & (w_ring_vc  != r_polarity);
        w_local_elig = local_req & ~r_full[w_local_vc] & (w_local_vc != r_polarity);
        w_contend    = w_ring_elig & w_local_elig;
        w_ring_gnt   = w_ring_elig & (~w_local_elig | (r_prio[w_fill_vc] == c_PRIO_RING));
        w_local_gnt  = w_local_elig & ~w_ring_gnt;
        w_fill       = w_ring_gnt | w_local_gnt;
        w_fill_data  = w_ring_gnt ? ring_data : local_data;
        w_drain      = r_full[r_polarity] & out_ro;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_polarity <= 1'b0;
            r_full     <= 2'b00;
            r_prio     <= {2{c_PRIO_RING}};
            r_sent_cnt <= '0;
        end else begin
            r_polarity <= ~r_polarity;
            if (w_drain) begin
                r_full[r_polarity] <= 1'b0;
                r_sent_cnt         <= r_sent_cnt + CNT_W'(1);
            end
            if (w_fill) begin
                r_full[w_fill_vc] <= 1'b1;
            end
            // Loser of a contended cycle gets priority next time.
            if (w_contend) begin
                r_prio[w_fill_vc] <= ~r_prio[w_fill_vc];
            end
        end
    end

    // Payload storage needs no reset; it is masked by the full flags.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_buf[w_fill_vc] <= w_fill_data;
        end
    end

    assign polarity  = r_polarity;
    assign ring_gnt  = w_ring_gnt;
    assign local_gnt = w_local_gnt;
    assign out_so    = w_drain;
    assign out_data  = r_full[r_polarity] ? r_buf[r_polarity] : '0;
    assign sent_cnt  = r_sent_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cardinal_ring_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cardinal_ring_out_arbiter
// Brief    : Directed scoreboard bench for cardinal_ring_out_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cardinal_ring_out_arbiter;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              polarity;
    logic              ring_req;
    logic [DATA_W-1:0] ring_data;
    logic              ring_gnt;
    logic              local_req;
    logic [DATA_W-1:0] local_data;
    logic              local_gnt;
    logic              out_so;
    logic              out_ro;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  sent_cnt;

    logic              exp_pol = 1'b0;
    logic [63:0]       exp_q[$];
    int                n_checks = 0;
    int                n_fail = 0;

    cardinal_ring_out_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .polarity  (polarity),
        .ring_req  (ring_req),
        .ring_data (ring_data),
        .ring_gnt  (ring_gnt),
        .local_req (local_req),
        .local_data(local_data),
        .local_gnt (local_gnt),
        .out_so    (out_so),
        .out_ro    (out_ro),
        .out_data  (out_data),
        .sent_cnt  (sent_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) exp_pol <= 1'b0;
        else        exp_pol <= ~exp_pol;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic align(input logic p);
        for (int k = 0; k < 4 && exp_pol !== p; k++) nxt();
    endtask

    function automatic logic [63:0] rpkt(input int k);
        return 64'hAAAA_0000_0000_0001 | (64'(k) << 8);
    endfunction

    function automatic logic [63:0] lpkt(input int k);
        return 64'hBBBB_0000_0000_0001 | (64'(k) << 8);
    endfunction

    // Monitor: phase tracking and scoreboard pop on every send-out strobe.
    initial begin
        forever begin
            @(negedge clk);
            chk("polarity", 64'(polarity), 64'(exp_pol));
            if (out_so === 1'b1) begin
                if (exp_q.size() == 0) chk("spurious_out_so", 64'(out_so), 64'd0);
                else                   chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rk;
        int lk;
        int n;
        int guard;

        ring_req = 1'b0; ring_data = '0; local_req = 1'b0; local_data = '0; out_ro = 1'b0;

        // Reset state
        #3;
        chk("rst_polarity",  64'(polarity),  64'd0);
        chk("rst_out_so",    64'(out_so),    64'd0);
        chk("rst_ring_gnt",  64'(ring_gnt),  64'd0);
        chk("rst_local_gnt", 64'(local_gnt), 64'd0);
        chk("rst_sent_cnt",  64'(sent_cnt),  64'd0);
        chk("rst_out_data",  out_data,       64'd0);
        #9 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("phase_toggle", 64'(polarity), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("idle_out_so",  64'(out_so),   64'd0);
            chk("idle_cnt",     64'(sent_cnt), 64'd0);
        end

        // Single local VC0 packet
        nxt();
        align(1'b1);
        out_ro = 1'b1; local_req = 1'b1; local_data = 64'h0000_0000_0000_A5A4;
        exp_q.push_back(64'h0000_0000_0000_A5A4);
        #1;
        chk("t2_local_gnt", 64'(local_gnt), 64'd1);
        chk("t2_ring_gnt",  64'(ring_gnt),  64'd0);
        nxt();
        local_req = 1'b0; local_data = '0;
        #1;
        chk("t2_out_so",   64'(out_so), 64'd1);
        chk("t2_out_data", out_data,    64'h0000_0000_0000_A5A4);
        nxt();
        chk("t2_sent_cnt", 64'(sent_cnt), 64'd1);

        // Ring and local contending for VC1
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(rpkt(k));
            exp_q.push_back(lpkt(k));
        end
        rk = 0; lk = 0; n = 0; guard = 0;
        while (n < 8 && guard < 40) begin
            ring_req  = (rk < 4); ring_data  = rpkt(rk);
            local_req = (lk < 4); local_data = lpkt(lk);
            #1;
            if (exp_pol == 1'b0) begin
                chk("t3_ring_gnt",  64'(ring_gnt),  (n % 2 == 0) ? 64'd1 : 64'd0);
                chk("t3_local_gnt", 64'(local_gnt), (n % 2 == 1) ? 64'd1 : 64'd0);
                n++;
            end else begin
                chk("t3_ring_gnt_off",  64'(ring_gnt),  64'd0);
                chk("t3_local_gnt_off", 64'(local_gnt), 64'd0);
            end
            if (ring_gnt)  rk++;
            if (local_gnt) lk++;
            nxt();
            guard++;
        end
        ring_req = 1'b0; local_req = 1'b0;
        chk("t3_ring_grants",  64'(rk), 64'd4);
        chk("t3_local_grants", 64'(lk), 64'd4);
        nxt();

        // Backpressure on VC0
        out_ro = 1'b0;
        align(1'b1);
        local_req = 1'b1; local_data = 64'hC0DE_0000_0000_0010;
        exp_q.push_back(64'hC0DE_0000_0000_0010);
        #1;
        chk("t4_fill_gnt", 64'(local_gnt), 64'd1);
        nxt();
        local_req = 1'b0; ring_req = 1'b1; ring_data = 64'hD00D_0000_0000_0020;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t4_blocked_so",  64'(out_so),   64'd0);
            chk("t4_blocked_gnt", 64'(ring_gnt), 64'd0);
            nxt();
        end
        out_ro = 1'b1;
        #1;
        chk("t4_release_so",  64'(out_so),   64'd1);
        chk("t4_release_gnt", 64'(ring_gnt), 64'd0);
        nxt();
        #1;
        chk("t4_ring_gnt", 64'(ring_gnt), 64'd1);
        exp_q.push_back(64'hD00D_0000_0000_0020);
        nxt();
        ring_req = 1'b0;
        #1;
        chk("t4_ring_so", 64'(out_so), 64'd1);
        nxt();
        chk("t4_sent_cnt", 64'(sent_cnt), 64'd11);

        // Asynchronous reset with both buffers full
        out_ro = 1'b0;
        align(1'b1);
        local_req = 1'b1; local_data = 64'h1111_0000_0000_0100;
        #1;
        chk("t5_fill_vc0", 64'(local_gnt), 64'd1);
        nxt();
        local_data = 64'h2222_0000_0000_0201;
        #1;
        chk("t5_fill_vc1", 64'(local_gnt), 64'd1);
        nxt();
        local_req = 1'b0;
        #1;
        chk("t5_vc1_held", out_data, 64'h2222_0000_0000_0201);
        #1 reset = 1'b0;
        #1;
        chk("t5_rst_polarity", 64'(polarity), 64'd0);
        chk("t5_rst_out_so",   64'(out_so),   64'd0);
        chk("t5_rst_cnt",      64'(sent_cnt), 64'd0);
        chk("t5_rst_data",     out_data,      64'd0);
        out_ro = 1'b1;
        #1;
        chk("t5_rst_ro_so", 64'(out_so), 64'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("t5_post_so", 64'(out_so), 64'd0);
        end

        // Counter wrap
        for (int k = 0; k < 65535; k++) begin
            local_req = 1'b1;
            local_data = {16'h5EED, 15'd0, 32'(k), ~exp_pol};
            exp_q.push_back(local_data);
            #1;
            chk("t6_gnt", 64'(local_gnt), 64'd1);
            nxt();
        end
        local_req = 1'b0;
        nxt();
        chk("t6_cnt_ffff", 64'(sent_cnt), 64'h0000_0000_0000_FFFF);
        local_req = 1'b1;
        local_data = {16'h5EED, 15'd0, 32'hFFFF_FFFF, ~exp_pol};
        exp_q.push_back(local_data);
        #1;
        chk("t6_last_gnt", 64'(local_gnt), 64'd1);
        nxt();
        local_req = 1'b0;
        nxt();
        chk("t6_cnt_wrap", 64'(sent_cnt), 64'd0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) nxt();
        nxt();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
